// File: rtl/mux_scan_sampler.sv
// Registered N:1 channel sampler with a valid/ready output stage and an optional
// round-robin auto-scan that advances one channel per captured sample.
module mux_scan_sampler #(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    input  logic                      go,
    input  logic                      scan_en,
    input  logic                      force_hi,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StFull = 1'b1;

    localparam logic [SEL_W:0]   NumChan = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LastSel = SEL_W'(CHANNELS - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] chan;
    logic [WIDTH-1:0] sample;
    logic             idle;
    logic             capture;
    logic             transfer;
    logic             sel_ok;

    // Decoded select; out-of-range values can never reach sel_q.
    always_comb begin
        chan = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                chan = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        idle     = (state_q == StIdle);
        transfer = !idle && dout_ready;
        // A held sample blocks capture until the consumer takes it.
        capture  = (idle || dout_ready) && (go || scan_en);
        sample   = force_hi ? {WIDTH{1'b1}} : chan;
        sel_ok   = ({1'b0, sel_in} < NumChan);

        state_d = state_q;
        if (capture) begin
            state_d = StFull;
        end else if (transfer) begin
            state_d = StIdle;
        end

        dout_d = capture ? sample : dout_q;

        sel_d  = sel_q;
        err_d  = err_q;
        wrap_d = 1'b0;
        if (sel_load) begin
            if (sel_ok) begin
                sel_d = sel_in;
            end else begin
                err_d = 1'b1;
            end
        end else if (scan_en && capture) begin
            if (sel_q == LastSel) begin
                sel_d  = '0;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dout_q  <= '0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == StFull);
    assign cur_sel    = sel_q;
    assign wrap       = wrap_q;
    assign sel_err    = err_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: a 16x1 instance for single-shot/backpressure
// and a 10x4 instance for scan, select collisions, bad selects and reset.
module tb_mux_scan_sampler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] din16;
    logic [3:0]  sel16, cs16;
    logic        load16, go16, scan16, fh16, rdy16;
    logic [0:0]  dout16;
    logic        v16, wrap16, err16;

    logic [39:0] din10;
    logic [3:0]  sel10, cs10;
    logic        load10, go10, scan10, fh10, rdy10;
    logic [3:0]  dout10;
    logic        v10, wrap10, err10;

    mux_scan_sampler #(.CHANNELS(16), .WIDTH(1)) u16 (
        .clk(clk), .rst(rst), .din(din16), .sel_in(sel16), .sel_load(load16), .go(go16),
        .scan_en(scan16), .force_hi(fh16), .dout(dout16), .dout_valid(v16),
        .dout_ready(rdy16), .cur_sel(cs16), .wrap(wrap16), .sel_err(err16)
    );

    mux_scan_sampler #(.CHANNELS(10), .WIDTH(4)) u10 (
        .clk(clk), .rst(rst), .din(din10), .sel_in(sel10), .sel_load(load10), .go(go10),
        .scan_en(scan10), .force_hi(fh10), .dout(dout10), .dout_valid(v10),
        .dout_ready(rdy10), .cur_sel(cs10), .wrap(wrap10), .sel_err(err10)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            last_exp = sb.pop_front();
            chk(tag, obs, last_exp);
        end
    endtask

    task automatic scan_step(input string tag);
        tick();
        chk({tag, "_valid"}, 32'(v10), 32'd1);
        pop_chk({tag, "_dout"}, 32'(dout10));
    endtask

    initial begin
        // Reset with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din16 = 16'($urandom); sel16 = 4'($urandom); load16 = 1'($urandom);
            go16 = 1'($urandom); scan16 = 1'($urandom); fh16 = 1'($urandom);
            rdy16 = 1'($urandom);
            din10 = {8'($urandom), 32'($urandom)}; sel10 = 4'($urandom);
            load10 = 1'($urandom); go10 = 1'($urandom); scan10 = 1'($urandom);
            fh10 = 1'($urandom); rdy10 = 1'($urandom);
            tick();
        end
        chk("rst16_dout", 32'(dout16), 0);
        chk("rst16_valid", 32'(v16), 0);
        chk("rst16_sel", 32'(cs16), 0);
        chk("rst16_err", 32'(err16), 0);
        chk("rst10_dout", 32'(dout10), 0);
        chk("rst10_valid", 32'(v10), 0);
        chk("rst10_sel", 32'(cs10), 0);
        chk("rst10_err", 32'(err10), 0);

        rst = 1'b0;
        din16 = 16'hA5C3; sel16 = '0; load16 = 0; go16 = 0; scan16 = 0; fh16 = 0; rdy16 = 0;
        for (int k = 0; k < 10; k++) din10[k*4 +: 4] = 4'(k);
        sel10 = '0; load10 = 0; go10 = 0; scan10 = 0; fh10 = 0; rdy10 = 0;

        // Single-shot on channel 5.
        load16 = 1; sel16 = 4'd5;
        tick();
        load16 = 0;
        chk("ss_sel", 32'(cs16), 5);
        go16 = 1; rdy16 = 1;
        sb.push_back(32'(din16[5]));
        tick();
        go16 = 0;
        chk("ss_valid", 32'(v16), 1);
        pop_chk("ss_dout", 32'(dout16));
        tick();
        chk("ss_valid_drop", 32'(v16), 0);
        chk("ss_dout_retain", 32'(dout16), last_exp);

        // Single-shot with force_hi.
        fh16 = 1; go16 = 1;
        sb.push_back(32'd1);
        tick();
        go16 = 0; fh16 = 0;
        chk("fh_valid", 32'(v16), 1);
        pop_chk("fh_dout", 32'(dout16));
        tick();
        chk("fh_valid_drop", 32'(v16), 0);

        // Backpressure on channel 3 with toggling din and a repeated go.
        load16 = 1; sel16 = 4'd3;
        tick();
        load16 = 0;
        go16 = 1; rdy16 = 0;
        sb.push_back(32'(din16[3]));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(v16), 1);
            chk("bp_hold", 32'(dout16), sb[0]);
            din16 = ~din16;
            fh16 = 1'(i);
            tick();
        end
        go16 = 0; fh16 = 0; rdy16 = 1;
        chk("bp_valid_end", 32'(v16), 1);
        pop_chk("bp_dout", 32'(dout16));
        tick();
        chk("bp_idle", 32'(v16), 0);

        // Scan wrap on the 10-channel instance.
        for (int i = 0; i < 12; i++) sb.push_back(32'(i % 10));
        scan10 = 1; rdy10 = 1;
        for (int i = 1; i <= 12; i++) begin
            scan_step("scan");
            chk("scan_wrap", 32'(wrap10), 32'(i == 10));
        end
        scan10 = 0;
        tick();
        chk("scan_stop_idle", 32'(v10), 0);
        chk("scan_stop_sel", 32'(cs10), 2);

        // Load vs. increment collision at cur_sel 7.
        load10 = 1; sel10 = 4'd5;
        tick();
        load10 = 0;
        sb.push_back(5); sb.push_back(6); sb.push_back(7); sb.push_back(2);
        scan10 = 1;
        scan_step("col");
        chk("col_sel6", 32'(cs10), 6);
        scan_step("col");
        chk("col_sel7", 32'(cs10), 7);
        load10 = 1; sel10 = 4'd2;
        scan_step("col");
        chk("col_sel_loaded", 32'(cs10), 2);
        chk("col_wrap", 32'(wrap10), 0);
        load10 = 0;
        scan_step("col");
        chk("col_sel3", 32'(cs10), 3);
        scan10 = 0;
        tick();
        chk("col_idle", 32'(v10), 0);

        // Out-of-range select.
        load10 = 1; sel10 = 4'd12;
        tick();
        load10 = 0;
        chk("bad_sel_kept", 32'(cs10), 3);
        chk("bad_err", 32'(err10), 1);
        chk("bad_err16_clear", 32'(err16), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("bad_err_sticky", 32'(err10), 1);

        // Reset mid-scan.
        scan10 = 1; rdy10 = 1;
        tick();
        tick();
        chk("mid_valid", 32'(v10), 1);
        rst = 1;
        tick();
        rst = 0; scan10 = 0;
        chk("mid_rst_dout", 32'(dout10), 0);
        chk("mid_rst_valid", 32'(v10), 0);
        chk("mid_rst_sel", 32'(cs10), 0);
        chk("mid_rst_err", 32'(err10), 0);
        chk("mid_rst_wrap", 32'(wrap10), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
# mux_scan_sampler

Parametrised, registered N:1 channel multiplexer with a valid/ready output handshake and an optional auto-scan mode. It is the sequential successor to the flat 16:1 select-and-force-high multiplexer in the MCNC-style combinational library. It adds the following over that multiplexer:
- configurable channel count and data width;
- a held select register;
- a round-robin scan that steps one channel per accepted sample.

It sits between a bank of sampled sources and a single-lane consumer.

## Interface
Parameters:
- CHANNELS, 16, number of input channels (2..256, need not be a power of two)
- WIDTH, 1, bits per channel
- SEL_W, $clog2(CHANNELS), select width (derived; do not override)

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  CHANNELS*WIDTH  channel k occupies din[k*WIDTH +: WIDTH]
- sel_in  in  SEL_W  select value to load
- sel_load  in  1  load sel_in into select register this cycle
- go  in  1  request one sample (single-shot mode)
- scan_en  in  1  1 = auto-scan mode, 0 = single-shot
- force_hi  in  1  captured sample is all-ones regardless of select
- dout  out  WIDTH  registered sample
- dout_valid  out  1  dout holds an unaccepted sample
- dout_ready  in  1  consumer accepts when dout_valid & dout_ready
- cur_sel  out  SEL_W  current select register value
- wrap  out  1  one-cycle pulse when scan wraps CHANNELS-1 -> 0
- sel_err  out  1  sticky: sel_load seen with sel_in >= CHANNELS

## Operation
- Reset values: dout=0, dout_valid=0, cur_sel=0, wrap=0, sel_err=0, FSM=IDLE.
- FSM states:
  - IDLE (no sample held).
  - FULL (sample held, dout_valid=1).
- Capture value: force_hi ? {WIDTH{1'b1}} : channel cur_sel of din.
  - Sampled at the capturing edge using the cur_sel value before any update on that same edge.
- IDLE -> FULL when go=1 or scan_en=1; capture on that edge.
- FULL with transfer (dout_valid & dout_ready):
  - scan_en=1: capture the next sample on the same edge and stay FULL (back-to-back).
  - scan_en=0 and go=1: capture and stay FULL.
  - otherwise -> IDLE, with dout_valid=0 and dout retaining its last value.
- FULL without transfer: dout and dout_valid are held stable. din, force_hi and select changes have no effect on dout.
- Select register update. Priority, highest first:
  1. sel_load with sel_in < CHANNELS: cur_sel <= sel_in.
  2. sel_load with sel_in >= CHANNELS: cur_sel unchanged; sel_err <= 1 (cleared only by rst).
  3. scan_en=1 and a capture occurs this edge: cur_sel <= (cur_sel == CHANNELS-1) ? 0 : cur_sel+1. wrap=1 for the cycle following a 0-transition.
- A capture and an increment on the same edge use the old cur_sel for the sample. The next capture uses the incremented value.
- sel_load on a capture edge: the capture uses the old cur_sel, the load wins over the increment, and wrap stays 0.
- go while FULL without transfer is ignored (not queued).
- rst mid-operation: every state returns to its reset value on the next edge and any held sample is discarded.

## Timing
- Latency: go or scan_en seen at edge N gives dout_valid=1 and a valid dout after edge N.
- Throughput: one sample per cycle in scan mode with dout_ready held high.
- cur_sel, wrap and sel_err are registered, with no combinational path from inputs.
- dout_valid has no combinational dependency on dout_ready.

## Test plan
- Reset check: hold rst 2 cycles with all inputs random. Required: dout=0, dout_valid=0, cur_sel=0, sel_err=0. Then release.
- Single-shot: CHANNELS=16, WIDTH=1, din=16'hA5C3, sel_load with sel_in=5, then go for 1 cycle, dout_ready=1.
  - dout=0 (bit 5 of A5C3) and dout_valid=1 for exactly one cycle.
  - Repeat with force_hi=1: dout=1.
- Backpressure: load sel=3, go, dout_ready=0 for 4 cycles while din toggles every cycle.
  - dout is held at its first-capture value with dout_valid=1 throughout.
  - Raising ready completes the transfer, then the FSM returns to IDLE.
- Scan wrap, non-power-of-two: CHANNELS=10, WIDTH=4, din channel k = k, scan_en=1, ready=1.
  - dout sequence 0,1,…,9,0,1.
  - wrap pulses once, the cycle after cur_sel returns to 0.
- Load vs. increment collision: scanning at cur_sel=7, sel_load sel_in=2 on a capture edge.
  - The captured sample is channel 7.
  - cur_sel=2, and the next sample is channel 2.
- Bad select: sel_load with sel_in=12 (CHANNELS=10).
  - cur_sel is unchanged and sel_err=1 and stays set until rst.
  - rst asserted mid-scan clears all state on the next edge.
